// File: rtl/gip_sram_dp_arbiter.sv
// Two-requester arbiter in front of a 2048x32 simple dual-port SRAM.
// Read and write ports are arbitrated independently; at most one read and one
// write are granted per cycle. Read data returns to the winner one cycle later.
//
// Parameters:
//   PRIORITY_MODE  0 = round-robin per port, 1 = A fixed priority with B starvation guard
//   STARVE_LIMIT   consecutive contended B losses on a port before B wins (mode 1 only)
// Ports:
//   sram_clock, sram_reset                    clock, synchronous active-high reset
//   a_req/a_write/a_address/a_write_data      requester A command (held until a_ack)
//   a_ack                                     combinational accept
//   a_read_data_valid/a_read_data             read return for A (data 0 when not valid)
//   b_*                                       same set for requester B
//   sram_read/sram_read_address/sram_read_data       SRAM read port
//   sram_write/sram_write_address/sram_write_data    SRAM write port
module gip_sram_dp_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic        sram_clock,
  input  logic        sram_reset,
  input  logic        a_req,
  input  logic        a_write,
  input  logic [10:0] a_address,
  input  logic [31:0] a_write_data,
  output logic        a_ack,
  output logic        a_read_data_valid,
  output logic [31:0] a_read_data,
  input  logic        b_req,
  input  logic        b_write,
  input  logic [10:0] b_address,
  input  logic [31:0] b_write_data,
  output logic        b_ack,
  output logic        b_read_data_valid,
  output logic [31:0] b_read_data,
  output logic        sram_read,
  output logic [10:0] sram_read_address,
  input  logic [31:0] sram_read_data,
  output logic        sram_write,
  output logic [10:0] sram_write_address,
  output logic [31:0] sram_write_data
);

  localparam int unsigned CntW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [CntW-1:0] StarveLim = CntW'(STARVE_LIMIT);
  localparam logic [CntW-1:0] CntMax    = '1;

  typedef enum logic {GntA = 1'b0, GntB = 1'b1} gnt_e;

  gnt_e            rd_last_q, rd_last_d;
  gnt_e            wr_last_q, wr_last_d;
  logic [CntW-1:0] rd_starve_q, rd_starve_d;
  logic [CntW-1:0] wr_starve_q, wr_starve_d;
  logic            a_rvalid_q, b_rvalid_q;

  logic a_rd, b_rd, a_wr, b_wr;
  logic rd_cont, wr_cont;
  logic rd_b_wins, wr_b_wins;
  logic a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt;

  always_comb begin
    // Reset masks every request, which forces acks and SRAM enables low.
    a_rd = a_req & ~a_write & ~sram_reset;
    b_rd = b_req & ~b_write & ~sram_reset;
    a_wr = a_req &  a_write & ~sram_reset;
    b_wr = b_req &  b_write & ~sram_reset;
    rd_cont = a_rd & b_rd;
    wr_cont = a_wr & b_wr;

    // Who wins a contended cycle on each port.
    if (PRIORITY_MODE == 0) begin
      rd_b_wins = (rd_last_q == GntA);
      wr_b_wins = (wr_last_q == GntA);
    end else begin
      rd_b_wins = (rd_starve_q == StarveLim);
      wr_b_wins = (wr_starve_q == StarveLim);
    end

    a_rd_gnt = a_rd & ~(rd_cont &  rd_b_wins);
    b_rd_gnt = b_rd & ~(rd_cont & ~rd_b_wins);
    a_wr_gnt = a_wr & ~(wr_cont &  wr_b_wins);
    b_wr_gnt = b_wr & ~(wr_cont & ~wr_b_wins);

    a_ack = a_rd_gnt | a_wr_gnt;
    b_ack = b_rd_gnt | b_wr_gnt;

    sram_read          = a_rd_gnt | b_rd_gnt;
    sram_read_address  = a_rd_gnt ? a_address : (b_rd_gnt ? b_address : 11'd0);
    sram_write         = a_wr_gnt | b_wr_gnt;
    sram_write_address = a_wr_gnt ? a_address : (b_wr_gnt ? b_address : 11'd0);
    sram_write_data    = a_wr_gnt ? a_write_data : (b_wr_gnt ? b_write_data : 32'd0);

    // Last-granted tracks every grant, contended or not.
    rd_last_d = rd_last_q;
    if (a_rd_gnt)      rd_last_d = GntA;
    else if (b_rd_gnt) rd_last_d = GntB;
    wr_last_d = wr_last_q;
    if (a_wr_gnt)      wr_last_d = GntA;
    else if (b_wr_gnt) wr_last_d = GntB;

    // Starvation counters: count contended B losses, clear on any B grant.
    rd_starve_d = rd_starve_q;
    if (b_rd_gnt)                         rd_starve_d = '0;
    else if (rd_cont && rd_starve_q != CntMax) rd_starve_d = rd_starve_q + 1'b1;
    wr_starve_d = wr_starve_q;
    if (b_wr_gnt)                         wr_starve_d = '0;
    else if (wr_cont && wr_starve_q != CntMax) wr_starve_d = wr_starve_q + 1'b1;

    // A reset arriving right after a grant discards the pending return at once.
    a_read_data_valid = a_rvalid_q & ~sram_reset;
    b_read_data_valid = b_rvalid_q & ~sram_reset;
    a_read_data       = a_read_data_valid ? sram_read_data : 32'd0;
    b_read_data       = b_read_data_valid ? sram_read_data : 32'd0;
  end

  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      rd_last_q   <= GntB;
      wr_last_q   <= GntB;
      rd_starve_q <= '0;
      wr_starve_q <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
    end else begin
      rd_last_q   <= rd_last_d;
      wr_last_q   <= wr_last_d;
      rd_starve_q <= rd_starve_d;
      wr_starve_q <= wr_starve_d;
      a_rvalid_q  <= a_rd_gnt;
      b_rvalid_q  <= b_rd_gnt;
    end
  end

endmodule
